// File: rtl/bit_serializer_if.sv
// Parallel-to-serial handshake bundle for bit_serializer.
//   slave  : the serializer side (takes words, drives the serial stream)
//   master : the word source / stream consumer side
// Signals:
//   data_i    word to send, LSB first          len_i   number of bits to send
//   valid_i   word present                     ready_o serializer can take a word
//   x_o       serial bit                       x_valid_o x_o carries a payload bit
//   done_o    last bit of a word               busy_o  serializer is shifting
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned LW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] data_i;
   logic [LW-1:0]    len_i;
   logic             valid_i;
   logic             ready_o;
   logic             x_o;
   logic             x_valid_o;
   logic             done_o;
   logic             busy_o;

   modport slave (
      input  data_i, len_i, valid_i,
      output ready_o, x_o, x_valid_o, done_o, busy_o
   );

   modport master (
      output data_i, len_i, valid_i,
      input  ready_o, x_o, x_valid_o, done_o, busy_o
   );
endinterface

// File: rtl/bit_serializer.sv
// Variable-length parallel-to-serial converter.
// Accepts a word plus a bit count, then emits that many bits LSB first,
// one per clock. A new word can be taken during the last bit so the
// serial stream has no gaps between back-to-back words.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    bit_serializer_if.slave (word handshake in, serial stream out)
module bit_serializer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   bit_serializer_if.slave    bus
);
   localparam int unsigned LW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             done_q, done_d;

   logic             last_c;
   logic             ready_c;
   logic             load_c;
   logic [LW-1:0]    len_eff_c;

   // Handshake decode; a zero-length word is accepted but never loaded.
   always_comb begin
      last_c    = (state_q == SHIFT) && (cnt_q == LW'(1));
      ready_c   = !reset && ((state_q == IDLE) || last_c);
      len_eff_c = (bus.len_i > LW'(WIDTH)) ? LW'(WIDTH) : bus.len_i;
      load_c    = bus.valid_i && ready_c && (len_eff_c != '0);
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (load_c) begin
               state_d = SHIFT;
               cnt_d   = len_eff_c;
               shift_d = bus.data_i;
               done_d  = (len_eff_c == LW'(1));
            end
         end
         SHIFT: begin
            if (last_c) begin
               if (load_c) begin
                  cnt_d   = len_eff_c;
                  shift_d = bus.data_i;
                  done_d  = (len_eff_c == LW'(1));
               end else begin
                  // Clearing the register keeps x_o low while idle.
                  state_d = IDLE;
                  cnt_d   = '0;
                  shift_d = '0;
               end
            end else begin
               cnt_d   = cnt_q - LW'(1);
               shift_d = shift_q >> 1;
               // The bit after this edge is the last one.
               done_d  = (cnt_q == LW'(2));
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready_o   = ready_c;
   assign bus.x_o       = shift_q[0];
   assign bus.x_valid_o = (state_q == SHIFT);
   assign bus.busy_o    = (state_q == SHIFT);
   assign bus.done_o    = done_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: a word-level model turns every
// accepted word into a queue of expected serial bits; a monitor pops one
// entry per output cycle and compares the serial outputs and ready_o.
module tb_bit_serializer;
   localparam int unsigned W  = 16;
   localparam int unsigned LW = $clog2(W) + 1;

   typedef struct {
      logic b;
      logic last;
   } exp_bit_t;

   logic clk;
   logic reset;
   bit_serializer_if #(.WIDTH(W)) bus ();

   bit_serializer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_bit_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   bit  acc    = 1'b0;
   bit  mon_en = 1'b0;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Word-level model: a word is taken when no bits remain after the current one.
   always @(posedge clk) begin
      int n;
      logic [W-1:0] d;
      mon_en = 1'b1;
      acc    = 1'b0;
      if (reset) begin
         exp_q.delete();
      end else if (bus.valid_i && exp_q.size() == 0) begin
         acc = 1'b1;
         n   = (int'(bus.len_i) > int'(W)) ? int'(W) : int'(bus.len_i);
         d   = bus.data_i;
         for (int i = 0; i < n; i++) begin
            exp_bit_t e;
            e.b    = d[i];
            e.last = (i == n - 1);
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: one expected bit per cycle while the queue holds any.
   always @(negedge clk) begin
      if (mon_en) begin
         check("ready_o", bus.ready_o, !reset && (exp_q.size() <= 1));
         if (exp_q.size() > 0) begin
            exp_bit_t e;
            e = exp_q.pop_front();
            check("x_valid_o", bus.x_valid_o, 1'b1);
            check("x_o",       bus.x_o,       e.b);
            check("done_o",    bus.done_o,    e.last);
            check("busy_o",    bus.busy_o,    1'b1);
         end else begin
            check("x_valid_o_idle", bus.x_valid_o, 1'b0);
            check("x_o_idle",       bus.x_o,       1'b0);
            check("done_o_idle",    bus.done_o,    1'b0);
            check("busy_o_idle",    bus.busy_o,    1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word until the model accepts it, then scramble idle inputs.
   task automatic send(input logic [W-1:0] d, input int l, input int gap);
      int n;
      bus.data_i  = d;
      bus.len_i   = LW'(l);
      bus.valid_i = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout at %0t: got no acceptance expected one within 200 cycles", $time);
      end
      bus.valid_i = 1'b0;
      for (int g = 0; g < gap; g++) begin
         bus.data_i = W'($urandom);
         bus.len_i  = LW'($urandom);
         tick();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout at %0t: got %0d bits pending expected 0", $time, exp_q.size());
      end
      repeat (2) tick();
   endtask

   task automatic pulse_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.len_i   = '0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Single word, then back-to-back words with valid held high.
      send(16'h0EDB, 12, 0);
      drain();
      send(16'h0EDB, 12, 0);
      send(16'h0005, 3, 0);
      drain();

      // Length corner cases.
      send(16'h0001, 1, 3);
      send(16'hFFFF, 0, 3);
      send(16'hA5C3, W + 5, 0);
      drain();
      send(16'h0003, 1, 0);
      send(16'h0002, 1, 0);
      send(16'h00FF, 0, 0);
      drain();

      // Reset in the middle of a word, then a clean restart.
      send(16'h0EDB, 12, 0);
      repeat (5) tick();
      pulse_reset(1);
      tick();
      send(16'h0EDB, 12, 0);
      drain();

      // Reset asserted while a word is offered: the word must be ignored.
      bus.data_i  = 16'h1234;
      bus.len_i   = LW'(8);
      bus.valid_i = 1'b1;
      reset       = 1'b1;
      tick();
      bus.valid_i = 1'b0;
      reset       = 1'b0;
      drain();

      // Random words, lengths, gaps and occasional resets.
      for (int i = 0; i < 150; i++) begin
         int l;
         l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                         : int'($urandom_range(1, W));
         send(W'($urandom), l, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0);
         if ($urandom_range(0, 40) == 0) begin
            repeat ($urandom_range(0, 8)) tick();
            pulse_reset($urandom_range(1, 2));
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL global_timeout at %0t: got still running expected finished", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
